// File: rtl/wb_stage.sv
// Write-back pipeline stage: holds one instruction from MEM, stalls loads until the
// data memory returns, extracts/extends the loaded value and drives the GPR write port.
module wb_stage #(
    parameter int PC_W = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            mem_valid_i,
    output logic            wb_allowin_o,
    input  logic [PC_W-1:0] mem_pc_i,
    input  logic            mem_we_i,
    input  logic [4:0]      mem_waddr_i,
    input  logic [31:0]     mem_result_i,
    input  logic [2:0]      mem_load_op_i,
    input  logic [1:0]      mem_addr_lo_i,
    input  logic            data_rvalid_i,
    input  logic [31:0]     data_rdata_i,
    input  logic            flush_i,
    output logic            we_o,
    output logic [4:0]      waddr_o,
    output logic [31:0]     wdata_o,
    output logic            wb_busy_o,
    output logic [4:0]      wb_waddr_o,
    output logic [PC_W-1:0] debug_pc_o,
    output logic            debug_we_o
);

    localparam logic [2:0] OP_LB  = 3'd1;
    localparam logic [2:0] OP_LBU = 3'd2;
    localparam logic [2:0] OP_LH  = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_LW  = 3'd5;

    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] pc;
        logic            we;
        logic [4:0]      waddr;
        logic [31:0]     result;
        logic [2:0]      load_op;
        logic [1:0]      addr_lo;
    } stage_t;

    stage_t stage_q, stage_d;

    logic        is_load;
    logic        ready_go;
    logic        wr_ok;
    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Load ops 6-7 are treated as plain ALU results and never wait for memory.
    assign is_load      = (stage_q.load_op >= OP_LB) && (stage_q.load_op <= OP_LW);
    assign ready_go     = !is_load || data_rvalid_i;
    assign wb_allowin_o = !stage_q.valid || ready_go;
    assign wr_ok        = stage_q.valid && stage_q.we && (stage_q.waddr != 5'd0);

    always_comb begin
        stage_d = stage_q;
        if (wb_allowin_o) begin
            stage_d.valid = mem_valid_i;
            if (mem_valid_i) begin
                stage_d.pc      = mem_pc_i;
                stage_d.we      = mem_we_i;
                stage_d.waddr   = mem_waddr_i;
                stage_d.result  = mem_result_i;
                stage_d.load_op = mem_load_op_i;
                stage_d.addr_lo = mem_addr_lo_i;
            end
        end
        if (flush_i) stage_d.valid = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) stage_q <= '0;
        else         stage_q <= stage_d;
    end

    // Halfword select uses addr_lo[1] only; misalignment is trapped upstream.
    assign shifted = data_rdata_i >> {stage_q.addr_lo, 3'b000};
    assign byte_v  = shifted[7:0];
    assign half_v  = stage_q.addr_lo[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];

    always_comb begin
        wdata_o = stage_q.result;
        case (stage_q.load_op)
            OP_LB:   wdata_o = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  wdata_o = {24'd0, byte_v};
            OP_LH:   wdata_o = {{16{half_v[15]}}, half_v};
            OP_LHU:  wdata_o = {16'd0, half_v};
            OP_LW:   wdata_o = data_rdata_i;
            default: wdata_o = stage_q.result;
        endcase
    end

    assign we_o       = wr_ok && ready_go && !flush_i;
    assign waddr_o    = stage_q.waddr;
    assign wb_busy_o  = wr_ok && !ready_go;
    assign wb_waddr_o = stage_q.waddr;
    assign debug_pc_o = stage_q.pc;
    assign debug_we_o = we_o;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected GPR writes are queued when an instruction is
// offered and checked when the stage issues the write.
module tb_wb_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        mem_valid_i;
    logic        wb_allowin_o;
    logic [31:0] mem_pc_i;
    logic        mem_we_i;
    logic [4:0]  mem_waddr_i;
    logic [31:0] mem_result_i;
    logic [2:0]  mem_load_op_i;
    logic [1:0]  mem_addr_lo_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        flush_i;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;
    logic        wb_busy_o;
    logic [4:0]  wb_waddr_o;
    logic [31:0] debug_pc_o;
    logic        debug_we_o;

    wb_stage #(.PC_W(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .mem_valid_i(mem_valid_i), .wb_allowin_o(wb_allowin_o),
        .mem_pc_i(mem_pc_i), .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i),
        .mem_result_i(mem_result_i), .mem_load_op_i(mem_load_op_i), .mem_addr_lo_i(mem_addr_lo_i),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .flush_i(flush_i),
        .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o), .wb_busy_o(wb_busy_o),
        .wb_waddr_o(wb_waddr_o), .debug_pc_o(debug_pc_o), .debug_we_o(debug_we_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic drive_mem(input logic v, input logic we, input logic [4:0] wa,
                             input logic [31:0] res, input logic [2:0] op,
                             input logic [1:0] lo, input logic [31:0] pc);
        mem_valid_i = v;   mem_we_i = we;      mem_waddr_i = wa;
        mem_result_i = res; mem_load_op_i = op; mem_addr_lo_i = lo; mem_pc_i = pc;
    endtask

    task automatic drive_idle();
        drive_mem(1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 32'd0);
    endtask

    // Settle after the inputs change, then retire any write against the scoreboard.
    task automatic obs();
        exp_t e;
        #1;
        if (we_o === 1'b1) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_write got waddr=%0d wdata=%h pc=%h, required no write",
                         waddr_o, wdata_o, debug_pc_o);
            end else begin
                e = sb.pop_front();
                if (waddr_o !== e.waddr || wdata_o !== e.wdata || debug_pc_o !== e.pc) begin
                    n_err++;
                    $display("FAIL sb_write got waddr=%0d wdata=%h pc=%h, required waddr=%0d wdata=%h pc=%h",
                             waddr_o, wdata_o, debug_pc_o, e.waddr, e.wdata, e.pc);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; flush_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'd0;
        drive_idle();
        obs();
        n_vec++;
        if (we_o !== 1'b0 || waddr_o !== 5'd0 || wdata_o !== 32'd0 || wb_allowin_o !== 1'b1 ||
            wb_busy_o !== 1'b0 || debug_pc_o !== 32'd0) begin
            n_err++;
            $display("FAIL reset_outputs got we=%b wa=%0d wd=%h allow=%b busy=%b pc=%h, required 0/0/0/1/0/0",
                     we_o, waddr_o, wdata_o, wb_allowin_o, wb_busy_o, debug_pc_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        obs();
        n_vec++;
        if (we_o !== 1'b0 || wb_allowin_o !== 1'b1 || wdata_o !== 32'd0) begin
            n_err++;
            $display("FAIL post_reset got we=%b allow=%b wd=%h, required 0/1/0", we_o, wb_allowin_o, wdata_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_alu();
        drive_mem(1'b1, 1'b1, 5'd5, 32'h0000_1234, 3'd0, 2'd0, 32'h100);
        sb.push_back('{5'd5, 32'h0000_1234, 32'h100});
        obs();
        @(negedge clk_i);
        drive_idle();
        obs();
        n_vec++;
        if (we_o !== 1'b1 || waddr_o !== 5'd5 || wdata_o !== 32'h0000_1234 ||
            wb_allowin_o !== 1'b1 || debug_we_o !== 1'b1) begin
            n_err++;
            $display("FAIL alu_write got we=%b wa=%0d wd=%h allow=%b dwe=%b, required 1/5/00001234/1/1",
                     we_o, waddr_o, wdata_o, wb_allowin_o, debug_we_o);
        end
        @(negedge clk_i);
    endtask

    // One load (or non-load op) with memory data returned in the first WB cycle.
    task automatic do_load(input logic [2:0] op, input logic [1:0] lo, input logic [31:0] rdata,
                           input logic [31:0] expd, input logic [4:0] wa, input logic [31:0] pc);
        drive_mem(1'b1, 1'b1, wa, 32'h5A5A_0001, op, lo, pc);
        sb.push_back('{wa, expd, pc});
        obs();
        @(negedge clk_i);
        drive_idle();
        data_rvalid_i = 1'b1; data_rdata_i = rdata;
        obs();
        n_vec++;
        if (we_o !== 1'b1) begin
            n_err++;
            $display("FAIL load_we op=%0d lo=%0d got we=%b, required 1", op, lo, we_o);
        end
        @(negedge clk_i);
        data_rvalid_i = 1'b0; data_rdata_i = 32'd0;
    endtask

    task automatic test_loads();
        do_load(3'd1, 2'd2, 32'h0080_0000, 32'hFFFF_FF80, 5'd3,  32'h110);
        do_load(3'd2, 2'd2, 32'h0080_0000, 32'h0000_0080, 5'd4,  32'h114);
        do_load(3'd3, 2'd2, 32'h8001_0000, 32'hFFFF_8001, 5'd6,  32'h118);
        do_load(3'd4, 2'd3, 32'h8001_0000, 32'h0000_8001, 5'd7,  32'h11C);
        do_load(3'd3, 2'd1, 32'hFFFF_7FFE, 32'h0000_7FFE, 5'd8,  32'h120);
        do_load(3'd1, 2'd1, 32'h1234_8000, 32'hFFFF_FF80, 5'd10, 32'h124);
        do_load(3'd2, 2'd3, 32'hC312_3456, 32'h0000_00C3, 5'd11, 32'h128);
        do_load(3'd5, 2'd3, 32'hCAFE_F00D, 32'hCAFE_F00D, 5'd12, 32'h12C);
        do_load(3'd6, 2'd0, 32'hCAFE_F00D, 32'h5A5A_0001, 5'd13, 32'h130);
    endtask

    task automatic test_back_to_back();
        drive_mem(1'b1, 1'b1, 5'd9, 32'd0, 3'd5, 2'd0, 32'h200);
        sb.push_back('{5'd9, 32'hDEAD_BEEF, 32'h200});
        obs();
        @(negedge clk_i);
        drive_mem(1'b1, 1'b1, 5'd7, 32'h0000_0077, 3'd0, 2'd0, 32'h204);
        for (int c = 0; c < 3; c++) begin
            data_rvalid_i = 1'b0;
            obs();
            n_vec++;
            if (wb_allowin_o !== 1'b0 || wb_busy_o !== 1'b1 || wb_waddr_o !== 5'd9 ||
                we_o !== 1'b0 || debug_pc_o !== 32'h200) begin
                n_err++;
                $display("FAIL wait_hold cyc=%0d got allow=%b busy=%b bwa=%0d we=%b pc=%h, required 0/1/9/0/200",
                         c, wb_allowin_o, wb_busy_o, wb_waddr_o, we_o, debug_pc_o);
            end
            @(negedge clk_i);
        end
        data_rvalid_i = 1'b1; data_rdata_i = 32'hDEAD_BEEF;
        sb.push_back('{5'd7, 32'h0000_0077, 32'h204});
        obs();
        n_vec++;
        if (we_o !== 1'b1 || wb_allowin_o !== 1'b1 || wb_busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL wait_release got we=%b allow=%b busy=%b, required 1/1/0", we_o, wb_allowin_o, wb_busy_o);
        end
        @(negedge clk_i);
        data_rvalid_i = 1'b0; data_rdata_i = 32'd0;
        drive_idle();
        obs();
        n_vec++;
        if (we_o !== 1'b1 || waddr_o !== 5'd7) begin
            n_err++;
            $display("FAIL successor_write got we=%b wa=%0d, required 1/7", we_o, waddr_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_r0();
        drive_mem(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 3'd0, 2'd0, 32'h300);
        obs();
        @(negedge clk_i);
        drive_mem(1'b1, 1'b1, 5'd0, 32'd0, 3'd5, 2'd0, 32'h304);
        obs();
        n_vec++;
        if (we_o !== 1'b0) begin
            n_err++;
            $display("FAIL r0_alu got we=%b, required 0", we_o);
        end
        @(negedge clk_i);
        drive_idle();
        obs();
        n_vec++;
        if (wb_busy_o !== 1'b0 || wb_allowin_o !== 1'b0 || we_o !== 1'b0) begin
            n_err++;
            $display("FAIL r0_load_wait got busy=%b allow=%b we=%b, required 0/0/0", wb_busy_o, wb_allowin_o, we_o);
        end
        @(negedge clk_i);
        data_rvalid_i = 1'b1; data_rdata_i = 32'h1111_1111;
        obs();
        n_vec++;
        if (we_o !== 1'b0) begin
            n_err++;
            $display("FAIL r0_load_ret got we=%b, required 0", we_o);
        end
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
    endtask

    task automatic test_flush();
        drive_mem(1'b1, 1'b1, 5'd4, 32'd0, 3'd5, 2'd0, 32'h400);
        obs();
        @(negedge clk_i);
        // Flush lands together with the load data and a new MEM offer: nothing survives.
        drive_mem(1'b1, 1'b1, 5'd6, 32'h0000_0066, 3'd0, 2'd0, 32'h404);
        flush_i = 1'b1; data_rvalid_i = 1'b1; data_rdata_i = 32'h2222_2222;
        obs();
        n_vec++;
        if (we_o !== 1'b0 || debug_we_o !== 1'b0) begin
            n_err++;
            $display("FAIL flush_we got we=%b dwe=%b, required 0/0", we_o, debug_we_o);
        end
        @(negedge clk_i);
        flush_i = 1'b0;
        drive_idle();
        obs();
        n_vec++;
        if (we_o !== 1'b0 || wb_allowin_o !== 1'b1 || wb_busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL flush_after got we=%b allow=%b busy=%b, required 0/1/0", we_o, wb_allowin_o, wb_busy_o);
        end
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
    endtask

    task automatic test_reset_wait();
        drive_mem(1'b1, 1'b1, 5'd8, 32'd0, 3'd5, 2'd0, 32'h500);
        obs();
        @(negedge clk_i);
        drive_idle();
        obs();
        n_vec++;
        if (wb_busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL rstwait_busy got busy=%b, required 1", wb_busy_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        n_vec++;
        if (we_o !== 1'b0 || waddr_o !== 5'd0 || wdata_o !== 32'd0 || wb_allowin_o !== 1'b1 ||
            wb_busy_o !== 1'b0 || debug_pc_o !== 32'd0) begin
            n_err++;
            $display("FAIL async_reset got we=%b wa=%0d wd=%h allow=%b busy=%b pc=%h, required 0/0/0/1/0/0",
                     we_o, waddr_o, wdata_o, wb_allowin_o, wb_busy_o, debug_pc_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1; data_rvalid_i = 1'b1; data_rdata_i = 32'h3333_3333;
        obs();
        n_vec++;
        if (we_o !== 1'b0 || wb_allowin_o !== 1'b1) begin
            n_err++;
            $display("FAIL rstwait_late_rvalid got we=%b allow=%b, required 0/1", we_o, wb_allowin_o);
        end
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_back_to_back();
        test_r0();
        test_flush();
        test_reset_wait();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain got %0d pending writes, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
